genaxis_packet_engine: RTL and testbench
========================================

// Module: genaxis_packet_engine
// PURPOSE
//  Consumer end of the generator descriptor stream {channel, pause[31:0], length[15:0]}.
//  Accepts one descriptor and idles for `pause` cycles.
//  Then emits one AXI-Stream packet of `length` bytes on TID=channel with a deterministic byte-ramp payload.
//  Sits between the descriptor generator and the generator's AXIS master output.
// PARAMETERS
//  ID_WIDTH    10  channel / TID width; descriptor is 48+ID_WIDTH bits
//  DATA_WIDTH  32  TDATA width in bits, multiple of 8; BYTES = DATA_WIDTH/8
// PORTS
//  clk                 in   1             clock, all logic on posedge
//  reset               in   1             asynchronous, active-high reset
//  cntrl_stop_i        in   1             abort pending pause, return to IDLE
//  descriptor_data_i   in   48+ID_WIDTH   {channel, pause[31:0], length[15:0]}
//  descriptor_valid_i  in   1             descriptor valid
//  descriptor_ready_o  out  1             descriptor accepted when valid&&ready
//  m_axis_tdata_o      out  DATA_WIDTH    payload
//  m_axis_tkeep_o      out  BYTES         byte enables
//  m_axis_tid_o        out  ID_WIDTH      channel of current packet
//  m_axis_tlast_o      out  1             last beat of packet
//  m_axis_tvalid_o     out  1             beat valid
//  m_axis_tready_i     in   1             downstream ready
//  busy_o              out  1             state != IDLE
//  pkt_count_o         out  32            packets completed (wraps at 2^32)
//  drop_count_o        out  32            zero-length descriptors consumed (wraps)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except descriptor_ready_o=1; counters 0.
//   Async assert drops tvalid immediately, including mid-packet.
//  FSM IDLE -> PAUSE | SEND | IDLE; PAUSE -> SEND | IDLE; SEND -> IDLE.
//  descriptor_ready_o = (state==IDLE), registered-state based, no comb path from valid.
//  IDLE, accept at cycle t: latch channel, length, pause.
//   pause>0 -> PAUSE (counter=pause). pause==0, length>0 -> SEND.
//   length==0, pause==0 -> stay IDLE, drop_count_o++.
//  PAUSE: counter decrements each cycle; leave when counter==1 -> exactly `pause` cycles in PAUSE.
//   Then SEND if length>0, else IDLE with drop_count_o++.
//   First tvalid therefore at cycle t+1+pause.
//   cntrl_stop_i in PAUSE -> IDLE next cycle; no packet, no count.
//  SEND: beats = ceil(length/BYTES), 16-bit beat counter b = 0..beats-1.
//   Byte lane i of beat b = (b*BYTES+i) mod 256; lane 0 = TDATA[7:0].
//   tkeep = all ones except last beat: low (length mod BYTES) bits set; all ones if remainder 0.
//   tlast=1 only on beat beats-1; tid constant for whole packet.
//  Handshake: beat advances only on tvalid&&tready.
//   tdata/tkeep/tid/tlast stable while tvalid&&!tready.
//   tvalid never deasserts mid-packet except on reset.
//   cntrl_stop_i ignored in SEND; packet always completes.
//  Last-beat handshake: pkt_count_o++ and state->IDLE; tvalid=0, ready=1 next cycle.
//   Minimum descriptor period is beats+1 cycles for pause==0.
//  length=65535 -> ceil(65535/BYTES) beats; counter must not overflow.
//  pause=0xFFFFFFFF is legal, full 32-bit count.
// TESTING
//  1. len=10, pause=0, ch=3, tready=1 -> beats t+1..t+3; keep F,F,3; bytes 00..09; tlast on beat 3; pkt_count=1.
//  2. len=8, pause=5 -> first tvalid exactly 6 cycles after accept; 2 beats, keep F,F; ready high again after beat 2.
//  3. len=20, tready toggling 1/0 each cycle -> 5 beats, data/keep/tlast held during stalls, ramp 00..13 intact.
//  4. len=0 pause=0 -> no tvalid, drop_count=1, ready stays 1; len=0 pause=4 -> ready low 4 cycles, drop_count=2.
//  5. pause=100, cntrl_stop_i at cycle 50 -> IDLE next cycle, no tvalid, pkt_count unchanged; next descriptor accepted.
//  6. reset asserted during beat 2 of len=16 -> tvalid=0 same cycle, counters 0; after release, new len=4 packet correct.

Source files
------------

// File: rtl/genaxis_packet_engine_if.sv
// AXI-Stream beat bus between the packet engine (master) and its downstream sink (slave).
interface genaxis_packet_engine_if #(
  parameter int ID_WIDTH   = 10,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [ID_WIDTH-1:0]     tid;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tid, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tid, tlast, tvalid, output tready);
endinterface

// File: rtl/genaxis_packet_engine.sv
// Consumes {channel, pause, length} descriptors, waits `pause` cycles, then streams a
// byte-ramp AXI-Stream packet of `length` bytes tagged with TID=channel.
module genaxis_packet_engine #(
  parameter int ID_WIDTH   = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cntrl_stop_i,
  input  logic [48+ID_WIDTH-1:0]   descriptor_data_i,
  input  logic                     descriptor_valid_i,
  output logic                     descriptor_ready_o,
  genaxis_packet_engine_if.master  m_axis,
  output logic                     busy_o,
  output logic [31:0]              pkt_count_o,
  output logic [31:0]              drop_count_o
);
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_SEND} state_t;

  state_t              state_q, state_d;
  logic [31:0]         pkt_q, pkt_d;
  logic [31:0]         drop_q, drop_d;
  logic [31:0]         pause_q, pause_d;
  logic [15:0]         beat_q, beat_d;
  logic [15:0]         last_q, last_d;
  logic [BYTES-1:0]    keep_last_q, keep_last_d;
  logic [7:0]          base_q, base_d;
  logic [ID_WIDTH-1:0] tid_q, tid_d;
  logic                nonempty_q, nonempty_d;

  logic [15:0]         desc_len;
  logic [31:0]         desc_pause;
  logic [ID_WIDTH-1:0] desc_ch;
  logic                send;
  logic                is_last;

  // floor((len-1)/BYTES) equals ceil(len/BYTES)-1 without needing a 17th bit
  function automatic logic [15:0] last_beat_idx(input logic [15:0] len);
    return (len - 16'd1) / 16'(BYTES);
  endfunction

  function automatic logic [BYTES-1:0] last_keep(input logic [15:0] len);
    logic [BYTES-1:0] k;
    int rem;
    rem = int'(len) % BYTES;
    for (int i = 0; i < BYTES; i++) k[i] = (rem == 0) || (i < rem);
    return k;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] ramp(input logic [7:0] base);
    logic [DATA_WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < BYTES; i++) d[8*i +: 8] = base + 8'(i);
    return d;
  endfunction

  assign desc_len   = descriptor_data_i[15:0];
  assign desc_pause = descriptor_data_i[47:16];
  assign desc_ch    = descriptor_data_i[48 +: ID_WIDTH];

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    drop_d      = drop_q;
    pause_d     = pause_q;
    beat_d      = beat_q;
    last_d      = last_q;
    keep_last_d = keep_last_q;
    base_d      = base_q;
    tid_d       = tid_q;
    nonempty_d  = nonempty_q;
    unique case (state_q)
      S_IDLE: begin
        if (descriptor_valid_i) begin
          tid_d       = desc_ch;
          pause_d     = desc_pause;
          last_d      = last_beat_idx(desc_len);
          keep_last_d = last_keep(desc_len);
          nonempty_d  = (desc_len != 16'd0);
          beat_d      = 16'd0;
          base_d      = 8'd0;
          if (desc_pause != 32'd0)    state_d = S_PAUSE;
          else if (desc_len != 16'd0) state_d = S_SEND;
          else                        drop_d  = drop_q + 32'd1;
        end
      end
      S_PAUSE: begin
        // stop takes priority even on the final pause cycle
        if (cntrl_stop_i) begin
          state_d = S_IDLE;
        end else if (pause_q == 32'd1) begin
          if (nonempty_q) begin
            state_d = S_SEND;
          end else begin
            state_d = S_IDLE;
            drop_d  = drop_q + 32'd1;
          end
        end else begin
          pause_d = pause_q - 32'd1;
        end
      end
      S_SEND: begin
        if (m_axis.tready) begin
          if (is_last) begin
            state_d = S_IDLE;
            pkt_d   = pkt_q + 32'd1;
          end else begin
            beat_d = beat_q + 16'd1;
            base_d = base_q + 8'(BYTES);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pkt_q   <= 32'd0;
      drop_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
    end
  end

  // Packet context is only consumed after being loaded at accept, so it needs no reset
  always_ff @(posedge clk) begin
    pause_q     <= pause_d;
    beat_q      <= beat_d;
    last_q      <= last_d;
    keep_last_q <= keep_last_d;
    base_q      <= base_d;
    tid_q       <= tid_d;
    nonempty_q  <= nonempty_d;
  end

  assign send    = (state_q == S_SEND);
  assign is_last = (beat_q == last_q);

  assign descriptor_ready_o = (state_q == S_IDLE);
  assign busy_o             = (state_q != S_IDLE);
  assign pkt_count_o        = pkt_q;
  assign drop_count_o       = drop_q;

  assign m_axis.tvalid = send;
  assign m_axis.tlast  = send && is_last;
  assign m_axis.tkeep  = !send ? '0 : (is_last ? keep_last_q : '1);
  assign m_axis.tdata  = send ? ramp(base_q) : '0;
  assign m_axis.tid    = send ? tid_q : '0;
endmodule

// File: tb/tb_genaxis_packet_engine.sv
// Scoreboard bench for genaxis_packet_engine: expected beats queued at descriptor time.
module tb_genaxis_packet_engine;
  localparam int IDW = 10;
  localparam int DW  = 32;
  localparam int B   = DW / 8;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [B-1:0]   keep;
    logic [IDW-1:0] id;
    logic           last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stop = 1'b0;
  logic            dvalid = 1'b0;
  logic [48+IDW-1:0] ddata = '0;
  logic            dready;
  logic            busy;
  logic [31:0]     pkt_count;
  logic [31:0]     drop_count;

  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_pkt = 0;
  int    exp_drop = 0;
  beat_t exp_q[$];

  genaxis_packet_engine_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) axis ();

  genaxis_packet_engine #(.ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
    .clk                (clk),
    .reset              (reset),
    .cntrl_stop_i       (stop),
    .descriptor_data_i  (ddata),
    .descriptor_valid_i (dvalid),
    .descriptor_ready_o (dready),
    .m_axis             (axis),
    .busy_o             (busy),
    .pkt_count_o        (pkt_count),
    .drop_count_o       (drop_count)
  );

  always #5 clk = ~clk;

  task automatic push_expected(input int len, input logic [IDW-1:0] ch);
    int nb;
    beat_t e;
    nb = (len + B - 1) / B;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < B; i++) e.data[8*i +: 8] = 8'((b * B + i) % 256);
      e.keep = '1;
      if (b == nb - 1 && (len % B) != 0) e.keep = B'((1 << (len % B)) - 1);
      e.id   = ch;
      e.last = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // Entered and left at a negedge; acceptance happens on the posedge in between.
  task automatic drive_desc(input logic [IDW-1:0] ch, input logic [31:0] pause, input logic [15:0] len);
    int w;
    w = 0;
    while (!dready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (dready !== 1'b1) begin
      n_err++;
      $display("FAIL desc_ready_timeout: ready=%b want 1", dready);
    end
    ddata  = {ch, pause, len};
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
  endtask

  task automatic test_reset();
    axis.tready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({dready, busy, axis.tvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_ctrl: ready/busy/tvalid=%b want 100", {dready, busy, axis.tvalid});
    end
    n_cmp++;
    if ({pkt_count, drop_count} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_counters: pkt=%0d drop=%0d want 0 0", pkt_count, drop_count);
    end
    n_cmp++;
    if ({axis.tdata, axis.tkeep, axis.tid, axis.tlast} !== '0) begin
      n_err++;
      $display("FAIL reset_axis: data=%h keep=%h tid=%h last=%b want 0", axis.tdata, axis.tkeep, axis.tid, axis.tlast);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready: got %b want 1", dready);
    end
  endtask

  task automatic test_single_packet();
    beat_t obs, e;
    int last_c;
    last_c = -1;
    axis.tready = 1'b1;
    push_expected(10, 10'd3);
    drive_desc(10'd3, 32'd0, 16'd10);
    n_cmp++;
    if (axis.tvalid !== 1'b1) begin
      n_err++;
      $display("FAIL t1_first_beat_latency: tvalid=%b want 1", axis.tvalid);
    end
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      obs = {axis.tdata, axis.tkeep, axis.tid, axis.tlast};
      if (axis.tvalid === 1'b1 && axis.tready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL t1_beat%0d: got %h want %h", c, obs, e);
        end
        last_c = c;
      end
    end
    n_cmp++;
    if (last_c != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL t1_beat_timing: last beat at %0d (left %0d) want 2 (left 0)", last_c, exp_q.size());
    end
    @(negedge clk);
    exp_pkt++;
    n_cmp++;
    if ({axis.tvalid, dready, pkt_count} !== {1'b0, 1'b1, 32'(exp_pkt)}) begin
      n_err++;
      $display("FAIL t1_after: tvalid=%b ready=%b pkt=%0d want 0 1 %0d", axis.tvalid, dready, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_pause();
    beat_t obs, e;
    int k, last_c;
    last_c = -1;
    axis.tready = 1'b1;
    push_expected(8, 10'd7);
    drive_desc(10'd7, 32'd5, 16'd8);
    n_cmp++;
    if ({dready, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL t2_pause_state: ready/busy=%b want 01", {dready, busy});
    end
    k = 0;
    while (axis.tvalid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k != 5) begin
      n_err++;
      $display("FAIL t2_pause_latency: tvalid after %0d more cycles want 5", k);
    end
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      obs = {axis.tdata, axis.tkeep, axis.tid, axis.tlast};
      if (axis.tvalid === 1'b1 && axis.tready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL t2_beat%0d: got %h want %h", c, obs, e);
        end
        last_c = c;
      end
    end
    @(negedge clk);
    exp_pkt++;
    n_cmp++;
    if (last_c != 1 || {dready, axis.tvalid, pkt_count} !== {1'b1, 1'b0, 32'(exp_pkt)}) begin
      n_err++;
      $display("FAIL t2_after: last_c=%0d ready=%b tvalid=%b pkt=%0d want 1 1 0 %0d", last_c, dready, axis.tvalid, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_backpressure();
    beat_t obs, e, held;
    bit held_v;
    int last_c, holds;
    last_c = -1;
    holds = 0;
    held_v = 1'b0;
    held = '0;
    push_expected(20, 10'd1);
    drive_desc(10'd1, 32'd0, 16'd20);
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      axis.tready = (c % 2 == 0);
      obs = {axis.tdata, axis.tkeep, axis.tid, axis.tlast};
      if (held_v) begin
        n_cmp++;
        holds++;
        if (axis.tvalid !== 1'b1 || obs !== held) begin
          n_err++;
          $display("FAIL t3_stall_hold%0d: tvalid=%b got %h want %h", c, axis.tvalid, obs, held);
        end
      end
      held_v = 1'b0;
      if (axis.tvalid === 1'b1 && axis.tready) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_err++;
          $display("FAIL t3_beat%0d: got %h want %h", c, obs, e);
        end
        last_c = c;
      end else if (axis.tvalid === 1'b1) begin
        held = obs;
        held_v = 1'b1;
      end
    end
    axis.tready = 1'b1;
    @(negedge clk);
    exp_pkt++;
    n_cmp++;
    if (last_c != 8 || holds != 4 || pkt_count !== 32'(exp_pkt)) begin
      n_err++;
      $display("FAIL t3_after: last_c=%0d holds=%0d pkt=%0d want 8 4 %0d", last_c, holds, pkt_count, exp_pkt);
    end
  endtask

  task automatic test_zero_length();
    bit seen;
    int k;
    drive_desc(10'd4, 32'd0, 16'd0);
    exp_drop++;
    n_cmp++;
    if ({dready, busy, axis.tvalid, drop_count} !== {3'b100, 32'(exp_drop)}) begin
      n_err++;
      $display("FAIL t4_drop_now: ready/busy/tvalid=%b drop=%0d want 100 %0d", {dready, busy, axis.tvalid}, drop_count, exp_drop);
    end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (axis.tvalid !== 1'b0 || dready !== 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL t4_idle_quiet: tvalid/ready moved got 1 want 0");
    end
    drive_desc(10'd4, 32'd4, 16'd0);
    k = 0;
    while (dready !== 1'b1 && k < 50) begin
      k++;
      @(negedge clk);
    end
    n_cmp++;
    if (k != 4) begin
      n_err++;
      $display("FAIL t4_ready_low_cycles: got %0d want 4", k);
    end
    exp_drop++;
    n_cmp++;
    if ({drop_count, pkt_count} !== {32'(exp_drop), 32'(exp_pkt)}) begin
      n_err++;
      $display("FAIL t4_counters: drop=%0d pkt=%0d want %0d %0d", drop_count, pkt_count, exp_drop, exp_pkt);
    end
  endtask

  task automatic test_stop();
    bit seen;
    beat_t obs, e;
    seen = 1'b0;
    axis.tready = 1'b1;
    drive_desc(10'd5, 32'd100, 16'd8);
    repeat (49) begin
      @(negedge clk);
      if (axis.tvalid !== 1'b0) seen = 1'b1;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if ({dready, busy, axis.tvalid, seen} !== 4'b1000) begin
      n_err++;
      $display("FAIL t5_stop: ready/busy/tvalid/seen=%b want 1000", {dready, busy, axis.tvalid, seen});
    end
    n_cmp++;
    if ({pkt_count, drop_count} !== {32'(exp_pkt), 32'(exp_drop)}) begin
      n_err++;
      $display("FAIL t5_counters: pkt=%0d drop=%0d want %0d %0d", pkt_count, drop_count, exp_pkt, exp_drop);
    end
    push_expected(4, 10'd9);
    drive_desc(10'd9, 32'd0, 16'd4);
    obs = {axis.tdata, axis.tkeep, axis.tid, axis.tlast};
    e = exp_q.pop_front();
    n_cmp++;
    if (axis.tvalid !== 1'b1 || obs !== e) begin
      n_err++;
      $display("FAIL t5_next_packet: tvalid=%b got %h want %h", axis.tvalid, obs, e);
    end
    @(negedge clk);
    exp_pkt++;
    n_cmp++;
    if (pkt_count !== 32'(exp_pkt)) begin
      n_err++;
      $display("FAIL t5_next_count: pkt=%0d want %0d", pkt_count, exp_pkt);
    end
  endtask

  task automatic test_reset_midpacket();
    beat_t obs, e;
    axis.tready = 1'b1;
    push_expected(16, 10'd2);
    drive_desc(10'd2, 32'd0, 16'd16);
    obs = {axis.tdata, axis.tkeep, axis.tid, axis.tlast};
    e = exp_q.pop_front();
    n_cmp++;
    if (axis.tvalid !== 1'b1 || obs !== e) begin
      n_err++;
      $display("FAIL t6_beat0: tvalid=%b got %h want %h", axis.tvalid, obs, e);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({axis.tvalid, busy, dready, pkt_count, drop_count} !== {3'b001, 64'd0}) begin
      n_err++;
      $display("FAIL t6_async_reset: tvalid/busy/ready=%b pkt=%0d drop=%0d want 001 0 0", {axis.tvalid, busy, dready}, pkt_count, drop_count);
    end
    exp_q.delete();
    exp_pkt = 0;
    exp_drop = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_expected(4, 10'd6);
    drive_desc(10'd6, 32'd0, 16'd4);
    obs = {axis.tdata, axis.tkeep, axis.tid, axis.tlast};
    e = exp_q.pop_front();
    n_cmp++;
    if (axis.tvalid !== 1'b1 || obs !== e) begin
      n_err++;
      $display("FAIL t6_after_reset_beat: tvalid=%b got %h want %h", axis.tvalid, obs, e);
    end
    @(negedge clk);
    exp_pkt++;
    n_cmp++;
    if ({pkt_count, axis.tvalid} !== {32'(exp_pkt), 1'b0}) begin
      n_err++;
      $display("FAIL t6_after_reset_count: pkt=%0d tvalid=%b want %0d 0", pkt_count, axis.tvalid, exp_pkt);
    end
  endtask

  initial begin
    axis.tready = 1'b0;
    test_reset();
    test_single_packet();
    test_pause();
    test_backpressure();
    test_zero_length();
    test_stop();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
